// File: rtl/lpif_gearbox_pkg.sv
// Shared widths, beat field offsets, beat struct and TX packer state encoding
// for the LPIF x8 asym1 half-rate gearbox.
package lpif_gearbox_pkg;

    localparam int BEAT_W = 273;
    localparam int WORD_W = 546;

    localparam int STATE_OFF     = 0;
    localparam int PROTID_OFF    = 4;
    localparam int DATA_OFF      = 6;
    localparam int DVALID_OFF    = 262;
    localparam int CRC_OFF       = 263;
    localparam int CRC_VALID_OFF = 271;
    localparam int VALID_OFF     = 272;

    // Packed structs list the MSB first, so state lands at bit 0.
    typedef struct packed {
        logic         valid;
        logic         crc_valid;
        logic [7:0]   crc;
        logic         dvalid;
        logic [255:0] data;
        logic [1:0]   protid;
        logic [3:0]   state;
    } lpif_beat_t;

    typedef enum logic [1:0] {
        EMPTY,
        HALF,
        FULL
    } tx_state_e;

endpackage

// File: rtl/lpif_asym1_half_unpack.sv
// RX unpacker: holds one 546-bit word and presents its two halves as
// consecutive registered beats, low half (older beat) first.
module lpif_asym1_half_unpack
    import lpif_gearbox_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic [WORD_W-1:0] word,
    input  logic              word_vld,
    output logic              word_rdy,
    output logic [BEAT_W-1:0] beat,
    output logic              beat_vld,
    input  logic              beat_rdy
);

    logic              held_reg;
    logic              phase_reg;
    logic [BEAT_W-1:0] high_reg;
    logic [BEAT_W-1:0] beat_reg;
    logic              word_load;

    // A new word may load in the same cycle the second beat drains.
    assign word_rdy  = !held_reg || (phase_reg && beat_rdy);
    assign word_load = word_vld && word_rdy;

    always_ff @(posedge clk) begin
        if (srst) begin
            held_reg  <= 1'b0;
            phase_reg <= 1'b0;
            high_reg  <= '0;
            beat_reg  <= '0;
        end else if (word_load) begin
            held_reg  <= 1'b1;
            phase_reg <= 1'b0;
            high_reg  <= word[BEAT_W +: BEAT_W];
            beat_reg  <= word[0 +: BEAT_W];
        end else if (held_reg && beat_rdy) begin
            if (!phase_reg) begin
                phase_reg <= 1'b1;
                beat_reg  <= high_reg;
            end else begin
                held_reg  <= 1'b0;
                phase_reg <= 1'b0;
            end
        end
    end

    assign beat     = beat_reg;
    assign beat_vld = held_reg;

endmodule

// File: rtl/lpif_txrx_x8_asym1_half_master_gearbox.sv
// Master-side LPIF x8 asym1 half-rate gearbox: packs two TX beats per word and
// splits RX words into two beats. Define LPIF_GEARBOX_FLUSH_EN to let flush close a half word.
module lpif_txrx_x8_asym1_half_master_gearbox
    import lpif_gearbox_pkg::*;
(
    input  logic              lclk,
    input  logic              lclk_rst,
    input  logic              dstrm_beat_vld,
    output logic              dstrm_beat_rdy,
    input  logic [3:0]        dstrm_state,
    input  logic [1:0]        dstrm_protid,
    input  logic [255:0]      dstrm_data,
    input  logic              dstrm_dvalid,
    input  logic [7:0]        dstrm_crc,
    input  logic              dstrm_crc_valid,
    input  logic              dstrm_valid,
    output logic [WORD_W-1:0] txfifo_downstream_data,
    output logic              txfifo_downstream_vld,
    input  logic              txfifo_downstream_rdy,
    input  logic [WORD_W-1:0] rxfifo_upstream_data,
    input  logic              rxfifo_upstream_vld,
    output logic              rxfifo_upstream_rdy,
    output logic [3:0]        ustrm_state,
    output logic [1:0]        ustrm_protid,
    output logic [255:0]      ustrm_data,
    output logic              ustrm_dvalid,
    output logic [7:0]        ustrm_crc,
    output logic              ustrm_crc_valid,
    output logic              ustrm_valid,
    output logic              ustrm_beat_vld,
    input  logic              ustrm_beat_rdy,
    input  logic              flush
);

    lpif_beat_t        dstrm_beat;
    tx_state_e         state_reg;
    logic [WORD_W-1:0] word_reg;
    logic              beat_acc;
    logic              word_drain;
    logic [BEAT_W-1:0] ustrm_beat;

    assign dstrm_beat = '{valid: dstrm_valid, crc_valid: dstrm_crc_valid, crc: dstrm_crc,
                          dvalid: dstrm_dvalid, data: dstrm_data, protid: dstrm_protid,
                          state: dstrm_state};

    assign dstrm_beat_rdy = (state_reg != FULL) || txfifo_downstream_rdy;
    assign beat_acc       = dstrm_beat_vld && dstrm_beat_rdy;
    assign word_drain     = (state_reg == FULL) && txfifo_downstream_rdy;

    always_ff @(posedge lclk) begin
        if (lclk_rst) begin
            state_reg <= EMPTY;
            word_reg  <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (beat_acc) begin
                        word_reg[0 +: BEAT_W] <= dstrm_beat;
                        state_reg             <= HALF;
                    end
                end
                HALF: begin
                    if (beat_acc) begin
                        word_reg[BEAT_W +: BEAT_W] <= dstrm_beat;
                        state_reg                  <= FULL;
                    end
`ifdef LPIF_GEARBOX_FLUSH_EN
                    else if (flush) begin
                        // Zero high half leaves beat1 valid=0 for the far end.
                        word_reg[BEAT_W +: BEAT_W] <= '0;
                        state_reg                  <= FULL;
                    end
`endif
                end
                FULL: begin
                    if (word_drain) begin
                        if (beat_acc) begin
                            word_reg[0 +: BEAT_W] <= dstrm_beat;
                            state_reg             <= HALF;
                        end else begin
                            state_reg <= EMPTY;
                        end
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end

`ifndef LPIF_GEARBOX_FLUSH_EN
    logic unused_flush;
    assign unused_flush = flush;
`endif

    assign txfifo_downstream_data = word_reg;
    assign txfifo_downstream_vld  = (state_reg == FULL);

    lpif_asym1_half_unpack u_unpack (
        .clk      (lclk),
        .srst     (lclk_rst),
        .word     (rxfifo_upstream_data),
        .word_vld (rxfifo_upstream_vld),
        .word_rdy (rxfifo_upstream_rdy),
        .beat     (ustrm_beat),
        .beat_vld (ustrm_beat_vld),
        .beat_rdy (ustrm_beat_rdy)
    );

    assign ustrm_state     = ustrm_beat[STATE_OFF +: 4];
    assign ustrm_protid    = ustrm_beat[PROTID_OFF +: 2];
    assign ustrm_data      = ustrm_beat[DATA_OFF +: 256];
    assign ustrm_dvalid    = ustrm_beat[DVALID_OFF];
    assign ustrm_crc       = ustrm_beat[CRC_OFF +: 8];
    assign ustrm_crc_valid = ustrm_beat[CRC_VALID_OFF];
    assign ustrm_valid     = ustrm_beat[VALID_OFF];

endmodule

// File: tb/tb_lpif_txrx_x8_asym1_half_master_gearbox.sv
// Bench for the master gearbox: directed scenarios plus randomized traffic
// compared against a queue model of beat pairing and word splitting.
module tb_lpif_txrx_x8_asym1_half_master_gearbox;

    logic         lclk = 1'b0;
    logic         lclk_rst;
    logic         dstrm_beat_vld;
    logic         dstrm_beat_rdy;
    logic [272:0] dbeat;
    logic [3:0]   dstrm_state;
    logic [1:0]   dstrm_protid;
    logic [255:0] dstrm_data;
    logic         dstrm_dvalid;
    logic [7:0]   dstrm_crc;
    logic         dstrm_crc_valid;
    logic         dstrm_valid;
    logic [545:0] txfifo_downstream_data;
    logic         txfifo_downstream_vld;
    logic         txfifo_downstream_rdy;
    logic [545:0] rxfifo_upstream_data;
    logic         rxfifo_upstream_vld;
    logic         rxfifo_upstream_rdy;
    logic [3:0]   ustrm_state;
    logic [1:0]   ustrm_protid;
    logic [255:0] ustrm_data;
    logic         ustrm_dvalid;
    logic [7:0]   ustrm_crc;
    logic         ustrm_crc_valid;
    logic         ustrm_valid;
    logic         ustrm_beat_vld;
    logic         ustrm_beat_rdy;
    logic         flush;
    logic [272:0] ubeat;

    always #5 lclk = ~lclk;

    assign dstrm_state     = dbeat[3:0];
    assign dstrm_protid    = dbeat[5:4];
    assign dstrm_data      = dbeat[261:6];
    assign dstrm_dvalid    = dbeat[262];
    assign dstrm_crc       = dbeat[270:263];
    assign dstrm_crc_valid = dbeat[271];
    assign dstrm_valid     = dbeat[272];
    assign ubeat = {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid,
                    ustrm_data, ustrm_protid, ustrm_state};

    lpif_txrx_x8_asym1_half_master_gearbox dut (
        .lclk                   (lclk),
        .lclk_rst               (lclk_rst),
        .dstrm_beat_vld         (dstrm_beat_vld),
        .dstrm_beat_rdy         (dstrm_beat_rdy),
        .dstrm_state            (dstrm_state),
        .dstrm_protid           (dstrm_protid),
        .dstrm_data             (dstrm_data),
        .dstrm_dvalid           (dstrm_dvalid),
        .dstrm_crc              (dstrm_crc),
        .dstrm_crc_valid        (dstrm_crc_valid),
        .dstrm_valid            (dstrm_valid),
        .txfifo_downstream_data (txfifo_downstream_data),
        .txfifo_downstream_vld  (txfifo_downstream_vld),
        .txfifo_downstream_rdy  (txfifo_downstream_rdy),
        .rxfifo_upstream_data   (rxfifo_upstream_data),
        .rxfifo_upstream_vld    (rxfifo_upstream_vld),
        .rxfifo_upstream_rdy    (rxfifo_upstream_rdy),
        .ustrm_state            (ustrm_state),
        .ustrm_protid           (ustrm_protid),
        .ustrm_data             (ustrm_data),
        .ustrm_dvalid           (ustrm_dvalid),
        .ustrm_crc              (ustrm_crc),
        .ustrm_crc_valid        (ustrm_crc_valid),
        .ustrm_valid            (ustrm_valid),
        .ustrm_beat_vld         (ustrm_beat_vld),
        .ustrm_beat_rdy         (ustrm_beat_rdy),
        .flush                  (flush)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [545:0] act, input logic [545:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [272:0] rbeat();
        logic [287:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        return t[272:0];
    endfunction

    function automatic logic [272:0] mk_beat(input logic [3:0] st, input logic vl, input logic [255:0] d);
        logic [272:0] b;
        b = rbeat();
        b[3:0]     = st;
        b[6 +: 256] = d;
        b[272]     = vl;
        return b;
    endfunction

    // Reference model: beats pair into words (older beat low), words split
    // into two beats (low half first). At most one word/pair is in flight.
    logic [545:0] wq[$];
    logic [272:0] bq[$];
    logic [272:0] part;
    bit           has_part = 0;
    int           tx_words = 0;
    bit           d_acc = 0;
    bit           r_acc = 0;
    bit           tx_stall_prev = 0;
    bit           rx_stall_prev = 0;
    logic [545:0] tx_prev;
    logic [272:0] rx_prev;

    always @(negedge lclk) begin
        if (lclk_rst) begin
            wq.delete();
            bq.delete();
            has_part      = 0;
            d_acc         = 0;
            r_acc         = 0;
            tx_stall_prev = 0;
            rx_stall_prev = 0;
        end else begin
            chk1("tx_vld", txfifo_downstream_vld, wq.size() > 0);
            chk1("dstrm_rdy", dstrm_beat_rdy, !(wq.size() > 0) || txfifo_downstream_rdy);
            if (tx_stall_prev) chkw("tx_hold", txfifo_downstream_data, tx_prev);
            if (txfifo_downstream_vld && txfifo_downstream_rdy && wq.size() > 0) begin
                chkw("tx_word", txfifo_downstream_data, wq.pop_front());
                tx_words++;
            end
            d_acc = dstrm_beat_vld && dstrm_beat_rdy;
            if (d_acc) begin
                if (has_part) begin
                    wq.push_back({dbeat, part});
                    has_part = 0;
                end else begin
                    part     = dbeat;
                    has_part = 1;
                end
            end
`ifdef LPIF_GEARBOX_FLUSH_EN
            else if (flush && has_part) begin
                wq.push_back({273'b0, part});
                has_part = 0;
            end
`endif
            tx_stall_prev = txfifo_downstream_vld && !txfifo_downstream_rdy;
            tx_prev       = txfifo_downstream_data;

            chk1("rx_vld", ustrm_beat_vld, bq.size() > 0);
            chk1("rx_rdy", rxfifo_upstream_rdy,
                 (bq.size() == 0) || (bq.size() == 1 && ustrm_beat_rdy));
            if (rx_stall_prev) chkw("rx_hold", 546'(ubeat), 546'(rx_prev));
            if (ustrm_beat_vld && ustrm_beat_rdy && bq.size() > 0)
                chkw("rx_beat", 546'(ubeat), 546'(bq.pop_front()));
            r_acc = rxfifo_upstream_vld && rxfifo_upstream_rdy;
            if (r_acc) begin
                bq.push_back(rxfifo_upstream_data[272:0]);
                bq.push_back(rxfifo_upstream_data[545:273]);
            end
            rx_stall_prev = ustrm_beat_vld && !ustrm_beat_rdy;
            rx_prev       = ubeat;
        end
    end

    task automatic tick();
        @(posedge lclk);
        #1;
    endtask

    logic [255:0] pat_a;
    logic [255:0] pat_b;
    logic [272:0] ba, bb, bc;
    logic [545:0] saved;
    int           w0;

    initial begin
        lclk_rst = 1'b1;
        dstrm_beat_vld = 1'b0;
        dbeat = '0;
        txfifo_downstream_rdy = 1'b0;
        rxfifo_upstream_data = '0;
        rxfifo_upstream_vld = 1'b0;
        ustrm_beat_rdy = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        chk1("rst_dstrm_rdy", dstrm_beat_rdy, 1'b1);
        chk1("rst_rx_rdy", rxfifo_upstream_rdy, 1'b1);
        lclk_rst = 1'b0;
        #1;
        chk1("rst_tx_vld", txfifo_downstream_vld, 1'b0);
        chk1("rst_u_vld", ustrm_beat_vld, 1'b0);
        chkw("rst_tx_data", txfifo_downstream_data, '0);
        chkw("rst_ubeat", 546'(ubeat), '0);

        // Two beats A..A / B..B produce one word, valid for exactly one cycle
        pat_a = {64{4'hA}};
        pat_b = {64{4'hB}};
        txfifo_downstream_rdy = 1'b1;
        dstrm_beat_vld = 1'b1;
        dbeat = mk_beat(4'h1, 1'b1, pat_a);
        tick();
        chk1("t1_vld_after_one", txfifo_downstream_vld, 1'b0);
        dbeat = mk_beat(4'h2, 1'b1, pat_b);
        tick();
        dstrm_beat_vld = 1'b0;
        chk1("t1_vld", txfifo_downstream_vld, 1'b1);
        saved = txfifo_downstream_data;
        chkw("t1_low_data", 546'(saved[6 +: 256]), 546'(pat_a));
        chkw("t1_high_data", 546'(saved[279 +: 256]), 546'(pat_b));
        tick();
        chk1("t1_vld_one_cycle", txfifo_downstream_vld, 1'b0);

        // Six back-to-back beats, no bubbles on dstrm_beat_rdy
        w0 = tx_words;
        dstrm_beat_vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dbeat = rbeat();
            #1;
            chk1("t2_no_bubble", dstrm_beat_rdy, 1'b1);
            tick();
        end
        dstrm_beat_vld = 1'b0;
        tick();
        tick();
        chk1("t2_three_words", tx_words == w0 + 3, 1'b1);

        // Backpressure while FULL, then drain with a same-cycle accept
        txfifo_downstream_rdy = 1'b0;
        dstrm_beat_vld = 1'b1;
        dbeat = rbeat();
        tick();
        dbeat = rbeat();
        tick();
        bc = rbeat();
        dbeat = bc;
        #1;
        saved = txfifo_downstream_data;
        for (int i = 0; i < 5; i++) begin
            chk1("t3_rdy_low", dstrm_beat_rdy, 1'b0);
            chk1("t3_vld_held", txfifo_downstream_vld, 1'b1);
            chkw("t3_word_stable", txfifo_downstream_data, saved);
            tick();
        end
        txfifo_downstream_rdy = 1'b1;
        #1;
        chk1("t3_rdy_release", dstrm_beat_rdy, 1'b1);
        tick();
        dstrm_beat_vld = 1'b0;
        chk1("t3_drained", txfifo_downstream_vld, 1'b0);

        // Flush the half word holding beat C
        flush = 1'b1;
        tick();
        flush = 1'b0;
`ifdef LPIF_GEARBOX_FLUSH_EN
        chk1("t5_flush_vld", txfifo_downstream_vld, 1'b1);
        saved = txfifo_downstream_data;
        chkw("t5_flush_high", 546'(saved[545:273]), '0);
        chk1("t5_flush_bit545", saved[545], 1'b0);
        chkw("t5_flush_low", 546'(saved[272:0]), 546'(bc));
        tick();
`else
        for (int i = 0; i < 6; i++) begin
            chk1("t5_no_flush_word", txfifo_downstream_vld, 1'b0);
            tick();
        end
`endif

        // RX word: beat0 state 3, stall, beat1 state 5
        ba = mk_beat(4'h3, 1'b1, rbeat()[255:0]);
        bb = mk_beat(4'h5, 1'b1, rbeat()[255:0]);
        rxfifo_upstream_data = {bb, ba};
        rxfifo_upstream_vld = 1'b1;
        ustrm_beat_rdy = 1'b1;
        #1;
        chk1("t4_rx_rdy_idle", rxfifo_upstream_rdy, 1'b1);
        tick();
        rxfifo_upstream_vld = 1'b0;
        chk1("t4_b0_vld", ustrm_beat_vld, 1'b1);
        chkw("t4_b0_state", 546'(ustrm_state), 546'(4'h3));
        chk1("t4_rx_rdy_b0", rxfifo_upstream_rdy, 1'b0);
        tick();
        ustrm_beat_rdy = 1'b0;
        #1;
        chkw("t4_b1_state", 546'(ustrm_state), 546'(4'h5));
        chk1("t4_rx_rdy_stall", rxfifo_upstream_rdy, 1'b0);
        tick();
        chkw("t4_b1_hold", 546'(ubeat), 546'(bb));
        ustrm_beat_rdy = 1'b1;
        #1;
        chk1("t4_rx_rdy_b1", rxfifo_upstream_rdy, 1'b1);
        tick();
        chk1("t4_rx_done", ustrm_beat_vld, 1'b0);

        // Reset with a half TX word and a held RX word
`ifdef LPIF_GEARBOX_FLUSH_EN
        dstrm_beat_vld = 1'b1;
        dbeat = rbeat();
        tick();
        dstrm_beat_vld = 1'b0;
`endif
        rxfifo_upstream_data = {rbeat(), rbeat()};
        rxfifo_upstream_vld = 1'b1;
        ustrm_beat_rdy = 1'b0;
        tick();
        rxfifo_upstream_vld = 1'b0;
        chk1("t6_rx_held", ustrm_beat_vld, 1'b1);
        lclk_rst = 1'b1;
        tick();
        lclk_rst = 1'b0;
        #1;
        chk1("t6_tx_vld", txfifo_downstream_vld, 1'b0);
        chk1("t6_u_vld", ustrm_beat_vld, 1'b0);
        chk1("t6_dstrm_rdy", dstrm_beat_rdy, 1'b1);
        chk1("t6_rx_rdy", rxfifo_upstream_rdy, 1'b1);
        chkw("t6_ubeat_zero", 546'(ubeat), '0);
        ba = rbeat();
        bb = rbeat();
        dstrm_beat_vld = 1'b1;
        dbeat = ba;
        tick();
        chk1("t6_empty_after_rst", txfifo_downstream_vld, 1'b0);
        dbeat = bb;
        tick();
        dstrm_beat_vld = 1'b0;
        chk1("t6_word_vld", txfifo_downstream_vld, 1'b1);
        chkw("t6_word", txfifo_downstream_data, {bb, ba});
        tick();

        // Randomized traffic on both directions
        w0 = tx_words;
        for (int c = 0; c < 3000; c++) begin
            if (!dstrm_beat_vld || d_acc) begin
                dstrm_beat_vld = ($urandom % 4) != 0;
                dbeat = rbeat();
            end
            if (!rxfifo_upstream_vld || r_acc) begin
                rxfifo_upstream_vld = ($urandom % 3) != 0;
                rxfifo_upstream_data = {rbeat(), rbeat()};
            end
            txfifo_downstream_rdy = ($urandom % 3) != 0;
            ustrm_beat_rdy = ($urandom % 4) != 0;
            flush = ($urandom % 10) == 0;
            tick();
        end
        dstrm_beat_vld = 1'b0;
        rxfifo_upstream_vld = 1'b0;
        txfifo_downstream_rdy = 1'b1;
        ustrm_beat_rdy = 1'b1;
        flush = 1'b0;
        repeat (10) tick();
        chk1("rand_rx_drained", bq.size() == 0, 1'b1);
        chk1("rand_tx_drained", wq.size() == 0, 1'b1);
        chk1("rand_tx_progress", tx_words > w0 + 300, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
